// File: rtl/div_pkg.sv
// Shared encodings for the iterative integer divider: operation codes,
// FSM states, default operand width and per-operation sign/select flags.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIN  = 2'b10
  } div_state_e;

  // Latched at accept time so operand bus changes mid-flight are harmless.
  typedef struct packed {
    logic is_rem;
    logic neg_q;
    logic neg_r;
  } div_flags_t;

  function automatic logic op_is_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, emit one quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvs always holds, so the shifted value fits in WIDTH+1 bits and
  // the top bit of the trial difference is a clean borrow flag.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_int.sv
// Multi-cycle integer divider for the EX stage: DIV/DIVU/REM/REMU with
// RISC-V style divide-by-zero and signed-overflow results.
module div_int
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic [1:0]       DIV_OP,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  div_flags_t       flg_q, flg_d;

  div_op_e          op_in;
  logic             sgn_in, rem_in, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign op_in  = div_op_e'(DIV_OP);
  assign sgn_in = op_is_signed(op_in);
  assign rem_in = op_is_rem(op_in);
  assign a_neg  = sgn_in & OP1[WIDTH-1];
  assign b_neg  = sgn_in & OP2[WIDTH-1];
  assign a_mag  = a_neg ? -OP1 : OP1;
  assign b_mag  = b_neg ? -OP2 : OP2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  // Zero results are left unnegated so -0 never escapes.
  assign q_fix = (flg_q.neg_q && quo_q != '0) ? -quo_q : quo_q;
  assign r_fix = (flg_q.neg_r && rem_q != '0) ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          flg_d = '{is_rem: rem_in, neg_q: a_neg ^ b_neg, neg_r: a_neg};
          if (OP2 == '0) begin
            res_d   = rem_in ? OP1 : '1;
            state_d = ST_FIN;
          end else if (sgn_in && OP1 == SMIN && OP2 == '1) begin
            res_d   = rem_in ? '0 : SMIN;
            state_d = ST_FIN;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            cnt_d   = CW'(WIDTH);
            state_d = ST_CALC;
          end
        end
      end
      // WIDTH steps while the counter runs down, then one cycle to sign-fix.
      ST_CALC: begin
        if (cnt_q != '0) begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CW'(1);
        end else begin
          res_d   = flg_q.is_rem ? r_fix : q_fix;
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign BUSY   = (state_q == ST_CALC);
  assign DONE   = (state_q == ST_FIN);
  assign RESULT = res_q;

endmodule

// File: tb/tb_div_int.sv
// Randomized and directed checks of div_int against an arithmetic model
// built on the language's own / and % operators.
module tb_div_int;

  logic        CLK = 1'b0;
  logic        RESET, START;
  logic [31:0] OP1, OP2, RESULT;
  logic [1:0]  DIV_OP;
  logic        BUSY, DONE;

  int          n_chk = 0;
  int          n_err = 0;
  logic [1:0]  cur_op;
  logic [31:0] cur_a, cur_b;

  always #5 CLK = ~CLK;

  div_int #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .OP1    (OP1),
    .OP2    (OP2),
    .DIV_OP (DIV_OP),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (op=%0d a=%h b=%h)", tag, got, exp, cur_op, cur_a, cur_b);
    end
  endtask

  // 00 DIV, 01 DIVU, 10 REM, 11 REMU
  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (b == 32'd0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // Called #1 after a rising edge with the DUT idle. inj >= 0 asserts a
  // stray START with fresh operands that many cycles into the operation.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [31:0] exp;
    int          exp_lat, lat;
    cur_op = op; cur_a = a; cur_b = b;
    exp     = model(op, a, b);
    exp_lat = model_lat(op, a, b);
    START = 1'b1; OP1 = a; OP2 = b; DIV_OP = op;
    @(posedge CLK); #1;
    START = 1'b0; OP1 = $urandom; OP2 = $urandom; DIV_OP = 2'($urandom);
    chk("busy_after_accept", 32'(BUSY), 32'(exp_lat != 0));
    lat = 0;
    while (!DONE && lat < 100) begin
      START = (lat == inj);
      if (lat == inj) begin
        OP1 = $urandom; OP2 = $urandom_range(1, 50); DIV_OP = 2'($urandom);
      end
      @(posedge CLK); #1;
      lat++;
    end
    START = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", RESULT, exp);
    chk("busy_in_fin", 32'(BUSY), 32'd0);
    // A START during FIN must be dropped.
    START = 1'b1; OP1 = $urandom; OP2 = $urandom | 32'd1; DIV_OP = 2'($urandom);
    @(posedge CLK); #1;
    START = 1'b0;
    chk("done_single", 32'(DONE), 32'd0);
    chk("fin_start_ignored", 32'(BUSY), 32'd0);
    chk("result_hold", RESULT, exp);
  endtask

  initial begin
    int seen;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          mode, inj;

    RESET = 1'b0; START = 1'b0; OP1 = '0; OP2 = '0; DIV_OP = '0;
    cur_op = '0; cur_a = '0; cur_b = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    RESET = 1'b1;

    // First START straight after reset release.
    do_op(2'd1, 32'd100, 32'd7, -1);
    do_op(2'd3, 32'd100, 32'd7, -1);
    do_op(2'd0, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(2'd1, 32'd5, 32'd0, -1);
    do_op(2'd2, 32'd5, 32'd0, -1);
    do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(2'd1, 32'd100, 32'd7, 10);
    do_op(2'd0, 32'd7, 32'hFFFF_FFFE, -1);
    do_op(2'd2, 32'd7, 32'hFFFF_FFFE, -1);
    do_op(2'd1, 32'hFFFF_FFFF, 32'd1, -1);
    do_op(2'd0, 32'd0, 32'd5, -1);
    do_op(2'd2, 32'hFFFF_FFFA, 32'd3, -1);
    do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, -1);

    // Reset mid-CALC aborts without a DONE pulse.
    cur_op = 2'd1; cur_a = 32'd100; cur_b = 32'd7;
    START = 1'b1; OP1 = 32'd100; OP2 = 32'd7; DIV_OP = 2'd1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (14) begin @(posedge CLK); #1; end
    RESET = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_result", RESULT, 32'd0);
    RESET = 1'b1; START = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    do_op(2'd1, 32'd9, 32'd3, -1);

    for (int i = 0; i < 60; i++) begin
      op   = 2'($urandom);
      mode = $urandom_range(0, 5);
      case (mode)
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = $urandom_range(0, 200);
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        3: begin a = $urandom; b = $urandom_range(1, 1000); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32) : -1;
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      do_op(op, a, b, inj);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
